// File: rtl/rng_distributor.sv
// Hands single words from an AXI4-Stream random source to one of several
// consumers at a time, choosing the requester by round-robin arbitration.
module rng_distributor #(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_PORTS   = 4,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [DATA_WIDTH-1:0]  in_tdata,
    input  logic                   in_tvalid,
    output logic                   in_tready,
    input  logic [NUM_PORTS-1:0]   req,
    output logic [DATA_WIDTH-1:0]  out_tdata,
    output logic [NUM_PORTS-1:0]   out_tvalid,
    input  logic [NUM_PORTS-1:0]   out_tready,
    output logic [NUM_PORTS-1:0]   grant,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] served_count
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DELIVER = 2'd2
    } state_t;

    state_t                 state;
    logic [IDX_W-1:0]       last_grant;
    logic [IDX_W-1:0]       owner;
    logic [IDX_W-1:0]       winner_idx;
    logic [IDX_W-1:0]       cand;
    logic [DATA_WIDTH-1:0]  data_reg;

    assign out_tdata = data_reg;

    // Walk offsets from the far end down so the nearest requester after
    // last_grant is the one left standing.
    always_comb begin
        winner_idx = '0;
        cand       = '0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            cand = IDX_W'((int'(last_grant) + k) % NUM_PORTS);
            if (req[cand]) begin
                winner_idx = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            grant        <= '0;
            owner        <= '0;
            last_grant   <= IDX_W'(NUM_PORTS - 1);
            data_reg     <= '0;
            served_count <= '0;
            in_tready    <= 1'b0;
            out_tvalid   <= '0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant     <= NUM_PORTS'(1) << winner_idx;
                        owner     <= winner_idx;
                        in_tready <= 1'b1;
                        busy      <= 1'b1;
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    if (in_tvalid) begin
                        data_reg   <= in_tdata;
                        in_tready  <= 1'b0;
                        out_tvalid <= grant;
                        state      <= DELIVER;
                    end
                end
                DELIVER: begin
                    // Only the owner's ready can complete the transfer.
                    if (|(out_tready & grant)) begin
                        last_grant   <= owner;
                        served_count <= served_count + COUNT_WIDTH'(1);
                        grant        <= '0;
                        out_tvalid   <= '0;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    grant      <= '0;
                    in_tready  <= 1'b0;
                    out_tvalid <= '0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rng_distributor.sv
// Randomised and directed bench for rng_distributor: a queue scoreboard fed
// from a round-robin model and an LFSR source checks every delivered word.
module tb_rng_distributor;

    localparam int DW = 8;
    localparam int NP = 4;
    localparam int CW = 4;

    logic          clk;
    logic          resetn;
    logic [DW-1:0] in_tdata;
    logic          in_tvalid;
    logic          in_tready;
    logic [NP-1:0] req;
    logic [DW-1:0] out_tdata;
    logic [NP-1:0] out_tvalid;
    logic [NP-1:0] out_tready;
    logic [NP-1:0] grant;
    logic          busy;
    logic [CW-1:0] served_count;

    rng_distributor #(.DATA_WIDTH(DW), .NUM_PORTS(NP), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .resetn(resetn),
        .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tready(in_tready),
        .req(req),
        .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tready(out_tready),
        .grant(grant), .busy(busy), .served_count(served_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    int            exp_port[$];
    logic [DW-1:0] exp_data[$];
    logic [DW-1:0] wrap_words[$];
    logic          record_wrap = 1'b0;

    int            model_last = NP - 1;
    logic [CW-1:0] model_count = '0;
    int            issued = 0;
    int            src_words = 0;
    int            port_hits[NP];
    logic [DW-1:0] src_lfsr = 8'h3F;
    logic          src_fire = 1'b0;
    logic [DW-1:0] last_delivered = '0;

    logic          count_check = 1'b0;
    logic [NP-1:0] prev_valid = '0;
    logic [DW-1:0] prev_data = '0;

    function automatic logic [DW-1:0] lfsrNext(input logic [DW-1:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    function automatic int rrWinner(input logic [NP-1:0] r, input int last);
        for (int k = 1; k <= NP; k++) begin
            if (r[(last + k) % NP]) return (last + k) % NP;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // One cycle of stimulus, driven shortly after the rising edge.
    task automatic applyStimulus(input logic [NP-1:0] req_v, input logic tvalid_v,
                                 input logic [NP-1:0] tready_v);
        int w;
        @(posedge clk);
        #2;
        req        = req_v;
        in_tvalid  = tvalid_v;
        in_tdata   = tvalid_v ? src_lfsr : DW'($urandom);
        out_tready = tready_v;
        if (resetn && !busy && req_v != '0) begin
            w = rrWinner(req_v, model_last);
            exp_port.push_back(w);
            model_last = w;
            issued++;
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_out_tvalid"}, 32'(out_tvalid), 32'd0);
        checkOutput({tag, "_in_tready"}, 32'(in_tready), 32'd0);
        checkOutput({tag, "_grant"}, 32'(grant), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_served_count"}, 32'(served_count), 32'd0);
        checkOutput({tag, "_out_tdata"}, 32'(out_tdata), 32'd0);
    endtask

    task automatic doReset();
        @(posedge clk);
        #3;
        resetn = 1'b0;
        req = '0; in_tvalid = 1'b0; out_tready = '0;
        #1;
        checkResetValues("reset");
        exp_port.delete();
        exp_data.delete();
        model_last  = NP - 1;
        model_count = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (busy || exp_port.size() != 0); i++)
            applyStimulus('0, 1'b1, '1);
        @(negedge clk);
        checkOutput("drain_idle", 32'(busy), 32'd0);
    endtask

    // Source: the LFSR only advances when a word was actually accepted.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (src_fire) begin
                src_lfsr = lfsrNext(src_lfsr);
                src_fire = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on every completed delivery.
    always @(negedge clk) begin
        int p;
        logic [DW-1:0] d;
        if (!resetn) begin
            prev_valid  = '0;
            count_check = 1'b0;
            src_fire    = 1'b0;
        end else begin
            if (count_check) begin
                checkOutput("served_count", 32'(served_count), 32'(model_count));
                count_check = 1'b0;
            end
            checkOutput("tvalid_onehot0", 32'((out_tvalid & (out_tvalid - 1'b1)) == '0), 32'd1);
            if (out_tvalid != '0) checkOutput("tvalid_vs_grant", 32'(out_tvalid), 32'(grant));
            if (prev_valid != '0) begin
                checkOutput("hold_tvalid", 32'(out_tvalid), 32'(prev_valid));
                checkOutput("hold_tdata", 32'(out_tdata), 32'(prev_data));
            end
            if (in_tvalid && in_tready) begin
                exp_data.push_back(in_tdata);
                src_fire = 1'b1;
                src_words++;
            end
            if ((out_tvalid & out_tready) != '0) begin
                if (exp_port.size() == 0 || exp_data.size() == 0) begin
                    checkOutput("unexpected_delivery", 32'(out_tvalid), 32'd0);
                end else begin
                    p = exp_port.pop_front();
                    d = exp_data.pop_front();
                    checkOutput("deliver_port", 32'(out_tvalid), 32'(1) << p);
                    checkOutput("deliver_data", 32'(out_tdata), 32'(d));
                    if (p >= 0 && p < NP) port_hits[p]++;
                end
                last_delivered = out_tdata;
                if (record_wrap) wrap_words.push_back(out_tdata);
                model_count = model_count + 1'b1;
                count_check = 1'b1;
                prev_valid  = '0;
            end else begin
                prev_valid = out_tvalid;
                prev_data  = out_tdata;
            end
        end
    end

    initial begin
        logic [DW-1:0] word;
        int snap;
        int start;
        resetn = 1'b1; req = '0; in_tvalid = 1'b0; out_tready = '0; in_tdata = '0;
        #1 resetn = 1'b0;
        doReset();

        // Single requester on port 2, source word 0x3F.
        applyStimulus(4'b0100, 1'b1, 4'hF);
        applyStimulus(4'b0000, 1'b1, 4'hF);
        @(negedge clk);
        checkOutput("single_fetch_in_tready", 32'(in_tready), 32'd1);
        checkOutput("single_fetch_tvalid", 32'(out_tvalid), 32'd0);
        checkOutput("single_fetch_grant", 32'(grant), 32'h4);
        applyStimulus(4'b0000, 1'b1, 4'hF);
        @(negedge clk);
        checkOutput("single_tvalid", 32'(out_tvalid), 32'h4);
        checkOutput("single_tdata", 32'(out_tdata), 32'h3F);
        applyStimulus(4'b0000, 1'b1, 4'hF);
        @(negedge clk);
        checkOutput("single_served", 32'(served_count), 32'd1);
        checkOutput("single_busy", 32'(busy), 32'd0);

        // Fairness: all ports requesting, source and consumers always ready.
        doReset();
        for (int i = 0; i < NP; i++) port_hits[i] = 0;
        for (int i = 0; i < 24; i++) applyStimulus(4'hF, 1'b1, 4'hF);
        drain();
        for (int i = 0; i < NP; i++) checkOutput($sformatf("fair_hits_%0d", i), 32'(port_hits[i]), 32'd2);

        // Source stall of 10 cycles while fetching for port 0.
        applyStimulus(4'b0001, 1'b0, 4'hF);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(4'b0000, 1'b0, 4'hF);
            @(negedge clk);
            checkOutput("stall_in_tready", 32'(in_tready), 32'd1);
            checkOutput("stall_tvalid", 32'(out_tvalid), 32'd0);
        end
        word = src_lfsr;
        applyStimulus(4'b0000, 1'b1, 4'hF);
        drain();
        checkOutput("stall_word", 32'(last_delivered), 32'(word));

        // Backpressure from port 1 for 5 cycles; other readies are noise.
        snap = src_words;
        applyStimulus(4'b0010, 1'b1, 4'b1101);
        applyStimulus(4'b0000, 1'b1, 4'b1101);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'b0000, 1'b1, 4'b1101);
            @(negedge clk);
            checkOutput("bp_tvalid", 32'(out_tvalid), 32'h2);
            checkOutput("bp_in_tready", 32'(in_tready), 32'd0);
            checkOutput("bp_src_words", 32'(src_words), 32'(snap + 1));
        end
        applyStimulus(4'b0000, 1'b1, 4'hF);
        drain();

        // Reset while delivering abandons the word and the count.
        doReset();
        applyStimulus(4'b0100, 1'b1, 4'h0);
        applyStimulus(4'b0000, 1'b1, 4'h0);
        applyStimulus(4'b0000, 1'b1, 4'h0);
        #1;
        checkOutput("pre_reset_tvalid", 32'(out_tvalid), 32'h4);
        resetn = 1'b0;
        #1;
        checkResetValues("async_reset");
        checkOutput("abandon_pending", 32'(exp_port.size()), 32'd1);
        exp_port.delete();
        exp_data.delete();
        model_last  = NP - 1;
        model_count = '0;
        @(negedge clk);
        resetn = 1'b1;
        applyStimulus(4'hF, 1'b1, 4'hF);
        applyStimulus(4'h0, 1'b1, 4'hF);
        @(negedge clk);
        checkOutput("post_reset_grant", 32'(grant), 32'h1);
        drain();

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom),
                          ($urandom_range(0, 3) != 0), 4'($urandom));
        end
        drain();

        // Counter wrap after 16 deliveries, words in LFSR order from seed 63.
        doReset();
        src_lfsr = 8'h3F;
        wrap_words.delete();
        record_wrap = 1'b1;
        start = issued;
        for (int i = 0; i < 200 && wrap_words.size() < 16; i++)
            applyStimulus((issued - start < 16) ? 4'hF : 4'h0, 1'b1, 4'hF);
        record_wrap = 1'b0;
        checkOutput("wrap_deliveries", 32'(wrap_words.size()), 32'd16);
        checkOutput("wrap_served_count", 32'(served_count), 32'd0);
        word = 8'h3F;
        for (int i = 0; i < wrap_words.size(); i++) begin
            checkOutput($sformatf("wrap_word_%0d", i), 32'(wrap_words[i]), 32'(word));
            word = lfsrNext(word);
        end
        drain();

        checkOutput("final_port_queue", 32'(exp_port.size()), 32'd0);
        checkOutput("final_data_queue", 32'(exp_data.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

endmodule
